// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sampling controller: sample width and FSM encoding.
package adc_pkg;

  localparam int ADC_W = 12;

  typedef logic [ADC_W-1:0] sample_t;
  typedef logic [2:0]       state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_OE        = 3'd4;
  localparam logic [2:0] ST_CAPTURE   = 3'd5;

endpackage

// File: rtl/adc_avg.sv
// Box-car averager: sums 2^AVG_LOG2 captured results, emits the truncated mean with a one-cycle valid.
module adc_avg
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    cap_i,
  input  sample_t data_i,
  output sample_t sample_data_o,
  output logic    sample_valid_o
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          data_q, data_d;
  logic             vld_q, vld_d;

  function automatic sample_t avg_trunc(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] shifted;
    shifted = s >> AVG_LOG2;
    return shifted[ADC_W-1:0];
  endfunction

  // The final capture of a group is folded in directly so no extra cycle is spent.
  assign sum = acc_q + ACC_W'(data_i);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    vld_d  = 1'b0;
    if (cap_i) begin
      if (cnt_q == LAST) begin
        acc_d  = '0;
        cnt_d  = '0;
        data_d = avg_trunc(sum);
        vld_d  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign sample_data_o  = data_q;
  assign sample_valid_o = vld_q;

endmodule

// File: rtl/adc_sampler.sv
// Handshake ADC controller: periodic start, EOC tracking with timeout, OE strobe, capture into averager.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int START_W       = 2,
  parameter int OE_W          = 2,
  parameter int TIMEOUT       = 64,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             adc_eoc,
  input  logic [ADC_W-1:0] adc_data,
  output logic             adc_start,
  output logic             adc_oe,
  output logic [ADC_W-1:0] sample_data,
  output logic             sample_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err
);

  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int STRB_M = (START_W > OE_W) ? START_W : OE_W;
  localparam int STRB_W = $clog2(STRB_M + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [PER_W-1:0]  per_q, per_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  state_t            state_q, state_d;
  logic              start_q, oe_q, busy_q, terr_q, terr_d, oerr_q, oerr_d;
  logic              tick, cap;

  assign tick = en && (per_q == PER_W'(SAMPLE_PERIOD - 1));

  always_comb begin
    per_d   = en ? (tick ? '0 : per_q + PER_W'(1)) : '0;
    state_d = state_q;
    strb_d  = strb_q;
    wait_d  = wait_q;
    terr_d  = terr_q;
    oerr_d  = oerr_q | (tick && (state_q != ST_IDLE));
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_START;
          strb_d  = '0;
        end
      end
      ST_START: begin
        if (strb_q == STRB_W'(START_W - 1)) begin
          state_d = ST_WAIT_LOW;
          strb_d  = '0;
          wait_d  = '0;
        end else begin
          strb_d = strb_q + STRB_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!adc_eoc) begin
          state_d = ST_WAIT_HIGH;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (adc_eoc) begin
          state_d = ST_OE;
          strb_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_OE: begin
        if (strb_q == STRB_W'(OE_W - 1)) begin
          state_d = ST_CAPTURE;
          strb_d  = '0;
        end else begin
          strb_d = strb_q + STRB_W'(1);
        end
      end
      ST_CAPTURE: begin
        cap     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q   <= '0;
      strb_q  <= '0;
      wait_q  <= '0;
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      per_q   <= per_d;
      strb_q  <= strb_d;
      wait_q  <= wait_d;
      state_q <= state_d;
      start_q <= (state_d == ST_START);
      oe_q    <= (state_d == ST_OE);
      busy_q  <= (state_d != ST_IDLE);
      terr_q  <= terr_d;
      oerr_q  <= oerr_d;
    end
  end

  adc_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk           (clk),
    .rst           (rst),
    .cap_i         (cap),
    .data_i        (adc_data),
    .sample_data_o (sample_data),
    .sample_valid_o(sample_valid)
  );

  assign adc_start   = start_q;
  assign adc_oe      = oe_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench: default-period sampler plus a fast-period instance for overrun behaviour.
module tb_adc_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Instance A: default parameters
  logic        en_a = 1'b0, eoc_a = 1'b1;
  logic [11:0] data_a = '0;
  logic        start_a, oe_a, valid_a, busy_a, terr_a, oerr_a;
  logic [11:0] sdata_a;

  // Instance B: short period for overrun
  logic        en_b = 1'b0, eoc_b = 1'b1;
  logic [11:0] data_b = 12'h123;
  logic        start_b, oe_b, valid_b, busy_b, terr_b, oerr_b;
  logic [11:0] sdata_b;

  adc_sampler #(.SAMPLE_PERIOD(1000), .START_W(2), .OE_W(2), .TIMEOUT(64), .AVG_LOG2(2)) u_dut (
    .clk(clk), .rst(rst), .en(en_a), .adc_eoc(eoc_a), .adc_data(data_a),
    .adc_start(start_a), .adc_oe(oe_a), .sample_data(sdata_a), .sample_valid(valid_a),
    .busy(busy_a), .timeout_err(terr_a), .overrun_err(oerr_a));

  adc_sampler #(.SAMPLE_PERIOD(16), .START_W(2), .OE_W(2), .TIMEOUT(64), .AVG_LOG2(2)) u_ovr (
    .clk(clk), .rst(rst), .en(en_b), .adc_eoc(eoc_b), .adc_data(data_b),
    .adc_start(start_b), .adc_oe(oe_b), .sample_data(sdata_b), .sample_valid(valid_b),
    .busy(busy_b), .timeout_err(terr_b), .overrun_err(oerr_b));

  // ADC models, updated on the falling edge; A takes data from a small table, else def_a
  logic        hang_a = 1'b0;
  logic [11:0] def_a = '0;
  logic [11:0] tbl_a [0:15];
  int          q_len_a = 0, q_rd_a = 0;
  logic        conv_a = 1'b0, conv_b = 1'b0;
  int          left_a = 0, left_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      conv_a = 1'b0; eoc_a = 1'b1;
    end else if (conv_a) begin
      left_a--;
      if (left_a == 0) begin eoc_a = 1'b1; conv_a = 1'b0; end
    end else if (start_a && !hang_a) begin
      conv_a = 1'b1; left_a = 10; eoc_a = 1'b0;
      if (q_rd_a < q_len_a) begin data_a = tbl_a[q_rd_a]; q_rd_a++; end
      else data_a = def_a;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      conv_b = 1'b0; eoc_b = 1'b1;
    end else if (conv_b) begin
      left_b--;
      if (left_b == 0) begin eoc_b = 1'b1; conv_b = 1'b0; end
    end else if (start_b) begin
      conv_b = 1'b1; left_b = 20; eoc_b = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [11:0] v);
    tbl_a[q_len_a] = v;
    q_len_a++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({start_a, oe_a, valid_a, busy_a, terr_a, oerr_a} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_a got %b want 000000", {start_a, oe_a, valid_a, busy_a, terr_a, oerr_a});
    end
    checks++;
    if (sdata_a !== 12'h000) begin errors++; $display("FAIL reset_data_a got %h want 000", sdata_a); end
    checks++;
    if ({start_b, oe_b, valid_b, busy_b, terr_b, oerr_b} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_b got %b want 000000", {start_b, oe_b, valid_b, busy_b, terr_b, oerr_b});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    int e, n, ovr_t;
    int rise [0:3];
    logic prev;
    e = cyc; n = 0; ovr_t = -1; prev = 1'b0;
    en_b = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (start_b && !prev) begin
        if (n < 4) rise[n] = cyc;
        n++;
      end
      if (oerr_b && ovr_t < 0) ovr_t = cyc;
      prev = start_b;
    end
    en_b = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL ovr_start_count got %0d want 3", n); end
    if (n >= 3) begin
      checks++;
      if (rise[0] - e !== 16) begin errors++; $display("FAIL ovr_first_start got %0d want 16", rise[0] - e); end
      checks++;
      if (rise[1] - rise[0] !== 32) begin errors++; $display("FAIL ovr_spacing1 got %0d want 32", rise[1] - rise[0]); end
      checks++;
      if (rise[2] - rise[1] !== 32) begin errors++; $display("FAIL ovr_spacing2 got %0d want 32", rise[2] - rise[1]); end
    end
    checks++;
    if (ovr_t - e !== 32) begin errors++; $display("FAIL ovr_flag_time got %0d want 32", ovr_t - e); end
  endtask

  task automatic test_defaults();
    int e, t, w, n, tv;
    def_a = 12'h800;
    e = cyc;
    en_a = 1'b1;
    n = 0;
    while (!start_a && n < 2000) begin step(); n++; end
    t = cyc;
    checks++;
    if (t - e !== 1000) begin errors++; $display("FAIL def_start_delay got %0d want 1000", t - e); end
    w = 0;
    while (start_a && w < 10) begin w++; step(); end
    checks++;
    if (w !== 2) begin errors++; $display("FAIL def_start_width got %0d want 2", w); end
    n = 0;
    while (!oe_a && n < 100) begin step(); n++; end
    w = 0;
    while (oe_a && w < 10) begin w++; step(); end
    checks++;
    if (w !== 2) begin errors++; $display("FAIL def_oe_width got %0d want 2", w); end
    n = 0;
    while (!valid_a && n < 5000) begin step(); n++; end
    tv = cyc;
    checks++;
    if (tv - e !== 4014) begin errors++; $display("FAIL def_first_valid got %0d want 4014", tv - e); end
    checks++;
    if (sdata_a !== 12'h800) begin errors++; $display("FAIL def_data1 got %h want 800", sdata_a); end
    step();
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL def_valid_pulse got %b want 0", valid_a); end
    n = 0;
    while (!valid_a && n < 5000) begin step(); n++; end
    checks++;
    if (cyc - tv !== 4000) begin errors++; $display("FAIL def_valid_period got %0d want 4000", cyc - tv); end
    checks++;
    if (sdata_a !== 12'h800) begin errors++; $display("FAIL def_data2 got %h want 800", sdata_a); end
    en_a = 1'b0;
    step();
  endtask

  task automatic test_averaging();
    int n;
    push_a(12'd100); push_a(12'd101); push_a(12'd102); push_a(12'd104);
    en_a = 1'b1;
    n = 0;
    while (!valid_a && n < 5000) begin step(); n++; end
    checks++;
    if (sdata_a !== 12'd101 || !valid_a) begin errors++; $display("FAIL avg_mixed got %0d want 101", sdata_a); end
    for (int i = 0; i < 4; i++) push_a(12'd4095);
    step();
    n = 0;
    while (!valid_a && n < 5000) begin step(); n++; end
    checks++;
    if (sdata_a !== 12'd4095 || !valid_a) begin errors++; $display("FAIL avg_full_scale got %0d want 4095", sdata_a); end
    en_a = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    hang_a = 1'b1;
    en_a = 1'b1;
    repeat (1065) step();
    checks++;
    if ({terr_a, busy_a} !== 2'b01) begin errors++; $display("FAIL to_before got terr,busy=%b want 01", {terr_a, busy_a}); end
    step();
    checks++;
    if ({terr_a, busy_a} !== 2'b10) begin errors++; $display("FAIL to_after got terr,busy=%b want 10", {terr_a, busy_a}); end
    hang_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(12'd200);
    n = 0;
    while (!valid_a && n < 5000) begin step(); n++; end
    checks++;
    if (sdata_a !== 12'd200 || !valid_a) begin errors++; $display("FAIL to_recover_data got %0d want 200", sdata_a); end
    checks++;
    if (terr_a !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", terr_a); end
  endtask

  task automatic test_reset_mid_oe();
    int n, pulses;
    n = 0;
    while (!oe_a && n < 1200) begin step(); n++; end
    checks++;
    if (oe_a !== 1'b1) begin errors++; $display("FAIL rst_oe_reached got %b want 1", oe_a); end
    rst = 1'b1;
    step();
    checks++;
    if ({oe_a, start_a, busy_a, terr_a, oerr_a} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_oe got %b want 00000", {oe_a, start_a, busy_a, terr_a, oerr_a});
    end
    checks++;
    if (oerr_b !== 1'b0) begin errors++; $display("FAIL rst_ovr_clear got %b want 0", oerr_b); end
    rst = 1'b0;
    en_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_a) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL rst_no_valid got %0d want 0", pulses); end
    checks++;
    if (sdata_a !== 12'h000) begin errors++; $display("FAIL rst_data_clear got %h want 000", sdata_a); end
  endtask

  task automatic test_enable();
    int e, n, starts;
    en_a = 1'b0;
    starts = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (start_a) starts++;
    end
    checks++;
    if (starts !== 0) begin errors++; $display("FAIL en_gated_starts got %0d want 0", starts); end
    e = cyc;
    en_a = 1'b1;
    n = 0;
    while (!start_a && n < 1100) begin step(); n++; end
    checks++;
    if (cyc - e !== 1000 || !start_a) begin errors++; $display("FAIL en_first_start got %0d want 1000", cyc - e); end
    en_a = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overrun();
    test_defaults();
    test_averaging();
    test_timeout();
    test_reset_mid_oe();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
